// File: rtl/score_display_rx.sv
// score_display_rx: readback decoder for the time-multiplexed two-digit
// seven-segment score bus. Reassembles ones/tens samples into frames,
// filters them for stability and presents BCD digits plus the binary score.
module score_display_rx #(
    parameter int STABLE_FRAMES = 2,
    parameter int TIMEOUT       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] ss0,
    input  logic [6:0] ss1,
    output logic [3:0] digit_ones,
    output logic [3:0] digit_tens,
    output logic [6:0] score,
    output logic       score_valid,
    output logic       score_update,
    output logic       seg_err
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] HAVE_ONES = 2'd1;
    localparam logic [1:0] HAVE_TENS = 2'd2;

    localparam logic [3:0] STABLE_MAX  = 4'(STABLE_FRAMES);
    localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT);

    // Inverse of the display font; bit 4 flags a legal decimal glyph.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b0111111: return 5'h10;
            7'b0000110: return 5'h11;
            7'b1011011: return 5'h12;
            7'b1001111: return 5'h13;
            7'b1100110: return 5'h14;
            7'b1101101: return 5'h15;
            7'b1111101: return 5'h16;
            7'b0000111: return 5'h17;
            7'b1111111: return 5'h18;
            7'b1100111: return 5'h19;
            default:    return 5'h00;
        endcase
    endfunction

    logic [1:0] state, state_nxt;
    logic [3:0] ones_lat, tens_lat;
    logic [7:0] pend_frame;
    logic [3:0] stab_cnt, stab_nxt;
    logic [7:0] tmo_cnt;

    logic [4:0] dec0, dec1;
    logic       ones_ph, tens_ph, blank, illegal;
    logic       frame_done, accept, timeout_hit;
    logic [3:0] frame_ones, frame_tens;
    logic [6:0] frame_score;

    assign dec0 = seg_decode(ss0);
    assign dec1 = seg_decode(ss1);

    // Sample classification, frame assembly decisions and filter next-state.
    always_comb begin
        // NOTE: every signal gets a value on every path so no latch is inferred.
        state_nxt   = state;
        ones_ph     = (ss0 != 7'd0) && (ss1 == 7'd0);
        tens_ph     = (ss1 != 7'd0) && (ss0 == 7'd0);
        blank       = (ss0 == 7'd0) && (ss1 == 7'd0);
        illegal     = ((ss0 != 7'd0) && (ss1 != 7'd0)) ||
                      (ones_ph && !dec0[4]) || (tens_ph && !dec1[4]);
        frame_done  = !illegal && (((state == HAVE_ONES) && tens_ph) ||
                                   ((state == HAVE_TENS) && ones_ph));
        frame_ones  = (state == HAVE_ONES) ? ones_lat : dec0[3:0];
        frame_tens  = (state == HAVE_TENS) ? tens_lat : dec1[3:0];
        frame_score = {frame_tens, 3'b000} + {2'b00, frame_tens, 1'b0} + {3'b000, frame_ones};

        if ({frame_tens, frame_ones} == pend_frame)
            stab_nxt = (stab_cnt >= STABLE_MAX) ? STABLE_MAX : stab_cnt + 4'd1;
        else
            stab_nxt = 4'd1;

        accept      = frame_done && (stab_nxt == STABLE_MAX) &&
                      (!score_valid || ({frame_tens, frame_ones} != {digit_tens, digit_ones}));
        timeout_hit = !frame_done && (tmo_cnt >= TIMEOUT_MAX - 8'd1);

        if (illegal || blank)
            state_nxt = IDLE;
        else if (ones_ph)
            state_nxt = (state == HAVE_TENS) ? IDLE : HAVE_ONES;
        else if (tens_ph)
            state_nxt = (state == HAVE_ONES) ? IDLE : HAVE_TENS;
    end

    // Frame assembly: phase FSM, newest-sample digit latches and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state    <= IDLE;
            ones_lat <= 4'd0;
            tens_lat <= 4'd0;
            seg_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            seg_err <= illegal;
            if (ones_ph && dec0[4])
                ones_lat <= dec0[3:0];
            if (tens_ph && dec1[4])
                tens_lat <= dec1[3:0];
        end
    end

    // Stability filter and accepted output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_frame   <= 8'd0;
            stab_cnt     <= 4'd0;
            digit_ones   <= 4'd0;
            digit_tens   <= 4'd0;
            score        <= 7'd0;
            score_valid  <= 1'b0;
            score_update <= 1'b0;
        end else begin
            score_update <= accept;
            if (frame_done) begin
                pend_frame <= {frame_tens, frame_ones};
                stab_cnt   <= stab_nxt;
            end else if (illegal || timeout_hit) begin
                stab_cnt <= 4'd0;
            end
            if (accept) begin
                digit_ones  <= frame_ones;
                digit_tens  <= frame_tens;
                score       <= frame_score;
                score_valid <= 1'b1;
            end else if (timeout_hit) begin
                score_valid <= 1'b0;
            end
        end
    end

    // Saturating count of cycles since the last completed frame.
    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= 8'd0;
        else if (frame_done)
            tmo_cnt <= 8'd0;
        else if (tmo_cnt != TIMEOUT_MAX)
            tmo_cnt <= tmo_cnt + 8'd1;
    end

endmodule
